// File: rtl/frac_mult_arbiter_if.sv
// Requester and multiplier signals of the shared fraction-multiplier arbiter.
// The slave modport is the arbiter; the master side drives requests and the multiplier returns.
interface frac_mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   Req;
  logic [4*NREQ-1:0] Mplier_in;
  logic [4*NREQ-1:0] Mcand_in;
  logic [NREQ-1:0]   Ack;
  logic [6:0]        Result;
  logic              Err;
  logic [NREQ-1:0]   Grant;
  logic              Busy;
  logic              St;
  logic [3:0]        Mplier;
  logic [3:0]        Mcand;
  logic [6:0]        Product;
  logic              Done;

  modport master (
    output Req, Mplier_in, Mcand_in, Product, Done,
    input  Ack, Result, Err, Grant, Busy, St, Mplier, Mcand
  );

  modport slave (
    input  Req, Mplier_in, Mcand_in, Product, Done,
    output Ack, Result, Err, Grant, Busy, St, Mplier, Mcand
  );
endinterface

// File: rtl/frac_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fraction multiplier among NREQ requesters,
// with a WAIT watchdog and a quiet FLUSH window so St never hits a multiplier mid-sequence.
module frac_mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 15,
  parameter int FLUSH_CYC = 6
) (
  input logic              CLK,
  input logic              Rst,
  frac_mult_arbiter_if.slave bus
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int FCW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_START, S_WAIT, S_ACK} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_d;
  logic [FCW-1:0]  flush_q;
  logic [WCW-1:0]  wait_q;
  logic [WCW-1:0]  wait_d;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] grant_q;
  logic [6:0]      result_q;
  logic            err_q;
  logic            busy_q;
  logic            st_q;
  logic [3:0]      mplier_q;
  logic [3:0]      mcand_q;

  // Winner is the requester at the smallest distance past the last owner.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   last);
    logic [PW-1:0] w;
    int            best;
    int            d;
    w    = last;
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2 * NREQ - int'(last) - 1) % NREQ;
      if (req[i] && (d < best)) begin
        best = d;
        w    = PW'(i);
      end
    end
    return w;
  endfunction

  always_comb win_d = rr_pick(bus.Req, ptr_q);
  assign wait_d = wait_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q  <= S_FLUSH;
      ptr_q    <= PW'(NREQ - 1);
      flush_q  <= '0;
      wait_q   <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b1;
      st_q     <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      st_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (flush_q == FCW'(FLUSH_CYC - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (|bus.Req) begin
            mplier_q <= bus.Mplier_in[{win_d, 2'b00} +: 4];
            mcand_q  <= bus.Mcand_in[{win_d, 2'b00} +: 4];
            grant_q  <= NREQ'(1) << win_d;
            ptr_q    <= win_d;
            busy_q   <= 1'b1;
            st_q     <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_d;
          // Done takes priority over a watchdog expiry landing in the same cycle.
          if (bus.Done) begin
            result_q <= bus.Product;
            ack_q    <= grant_q;
            err_q    <= 1'b0;
            state_q  <= S_ACK;
          end else if (wait_d == WCW'(TIMEOUT)) begin
            result_q <= '0;
            ack_q    <= grant_q;
            err_q    <= 1'b1;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          grant_q <= '0;
          if (err_q) begin
            flush_q <= '0;
            state_q <= S_FLUSH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign bus.Ack    = ack_q;
  assign bus.Result = result_q;
  assign bus.Err    = err_q;
  assign bus.Grant  = grant_q;
  assign bus.Busy   = busy_q;
  assign bus.St     = st_q;
  assign bus.Mplier = mplier_q;
  assign bus.Mcand  = mcand_q;
endmodule

// File: doc/frac_mult_arbiter.md
Name: frac_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fraction_multiplication instance among NREQ requesters. It latches the winning requester's operands and pulses the multiplier's St. It then waits for Done, captures Product and returns it with a one-cycle Ack. A watchdog catches a multiplier that never completes, and a flush window keeps St from being issued while the multiplier may still be mid-sequence. The multiplier itself has no reset.

Parameters:
NREQ, 4, number of requesters (2..8 supported)
TIMEOUT, 15, WAIT-state cycles without Done before the operation is aborted with Err
FLUSH_CYC, 6, quiet cycles after reset or timeout before the next grant

Ports:
CLK  in  1  clock, all logic on posedge
Rst  in  1  reset: one clock; synchronous, active-high
Req  in  NREQ  request per requester; held with operands until that requester's Ack
Mplier_in  in  4*NREQ  requester i multiplier at [4i+3:4i], signed Q1.3
Mcand_in  in  4*NREQ  requester i multiplicand at [4i+3:4i], signed Q1.3
Ack  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
Result  out  7  product (signed Q1.6), valid while Ack high, held until the next Ack
Err  out  1  high with Ack when the operation timed out; Result is 0 then
Grant  out  NREQ  one-hot owner, high from START through ACK inclusive
Busy  out  1  high in every state except IDLE
St  out  1  start pulse to the multiplier
Mplier  out  4  operand to the multiplier, from the internal register
Mcand  out  4  operand to the multiplier, from the internal register; stable START..ACK
Product  in  7  product from the multiplier
Done  in  1  done from the multiplier, high in its final state

Behaviour:
- States: FLUSH, IDLE, START, WAIT, ACK. Rst forces FLUSH from any state, including mid-operation.
- Reset values: Ack=0, Grant=0, Err=0, Result=0, St=0, operand registers=0, Busy=1, flush count=0, wait count=0, RR pointer=NREQ-1 so requester 0 has first priority.
- FLUSH: count FLUSH_CYC cycles, ignoring Req and Done, then go to IDLE. This lets a running multiplier return to its state 0.
- IDLE, if Req!=0:
  - Pick the first set bit starting at (pointer+1) mod NREQ.
  - Latch its Mplier_in/Mcand_in slices into the operand registers, set Grant, update the pointer to the winner, go to START.
  - With no request, stay in IDLE.
- START: St=1 for exactly this one cycle (St = state==START). Clear the wait count, go to WAIT.
- WAIT:
  - Increment the wait count each cycle.
  - Done=1: register Result<=Product, Ack[winner]<=1, Err<=0, go to ACK.
  - Else if the count reaches TIMEOUT: Result<=0, Ack[winner]<=1, Err<=1, go to ACK and afterwards FLUSH.
  - Done and timeout in the same cycle: Done wins.
- ACK: Ack/Err high for this single cycle. Next state is IDLE, or FLUSH after a timeout. Clear Grant on exit. The requester must drop or renew Req before IDLE samples, which is the first edge after ACK.
- Nominal timing: Req sampled at edge e0; St high e0..e1; multiplier Done high e5..e6; Ack high e6..e7; next grant possible at e8. That is 8 cycles per operation, 6-cycle Req-to-Ack latency.
- Req dropped before Ack: the operation still completes. Ack is still pulsed and may be ignored.
- Done seen outside WAIT: ignored.
- Operands: changes on Mplier_in/Mcand_in after the grant have no effect. Mcand/Mplier outputs change only on an IDLE grant.
- Fairness: each requester is served at most once per NREQ grants while others wait. The pointer wraps NREQ-1 -> 0.

Test Plan:
1. Rst high 2 cycles, then Req=0001, Mplier_in[3:0]=0100, Mcand_in[3:0]=0100 -> St one cycle at e1. Ack=0001 at e6. Result=7'b0010000, Err=0.
2. Req=0110 held; requester 1 gets 1100*0100, requester 2 gets 0100*0100 -> Ack order requester 1 (Result=7'b1110000), then requester 2 (Result=7'b0010000). Acks 8 cycles apart.
3. Req=1111 held and each requester re-requests after its Ack -> grant order 0,1,2,3,0,1. No requester is acked twice before all others.
4. Done tied 0, Req=0001 -> Ack=0001 with Err=1, Result=0 after TIMEOUT WAIT cycles. Then Busy stays high for FLUSH_CYC cycles, and a new Req is not granted before FLUSH ends.
5. Rst asserted 2 cycles after St -> outputs return to reset values next edge. No St for FLUSH_CYC cycles. The next request completes with the correct Result.
6. Mcand_in for the owner changed during WAIT -> the Mcand output is unchanged and Result matches the operands latched at grant.
